// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned     XLEN        = 32;
   localparam int unsigned     INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] RESET_PC    = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0013;

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc,instr} entries; flush dominates push.
// Head is read straight from the storage flops, so a push is never visible the same cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output fetch_entry_t             head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty_q, empty_d;
   logic          full_q, full_d;
   logic          push_ok, pop_ok;

   // A push into a full queue is only legal when the head leaves the same cycle.
   assign pop_ok  = pop && !empty_q;
   assign push_ok = push && (!full_q || pop_ok);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      end
      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = empty_q;
   assign count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues credit-limited memory requests and queues words for decode.
// Optional FETCH_PERF_EN adds fetch/flush/stall performance counters.
module instr_fetch_queue #(
   parameter int unsigned     XLEN     = fetch_pkg::XLEN,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetch_cnt,
   output logic [31:0]     perf_flush_cnt,
   output logic [31:0]     perf_stall_cnt
`endif
);

   localparam int unsigned     CW         = $clog2(DEPTH) + 1;
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(fetch_pkg::INSTR_BYTES);
   localparam logic [XLEN-1:0] RESET_AL   = RESET_PC & ALIGN_MASK;
   localparam logic [CW:0]     CREDITS    = (CW+1)'(DEPTH);

   fetch_pkg::fetch_state_t state_q, state_d;
   logic [XLEN-1:0]         fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]         rsp_pc_q, rsp_pc_d;
   logic [XLEN-1:0]         req_addr_q, req_addr_d;
   logic                    req_valid_q, req_valid_d;
   logic [CW-1:0]           inflight_q, inflight_d;
   logic [CW-1:0]           drop_cnt_q, drop_cnt_d;
   logic [CW-1:0]           occ_next;
   logic [CW:0]             credit_used;
   logic [XLEN-1:0]         redirect_al;

   logic                    fire, pop, push, rsp_drop;
   logic                    fifo_full, fifo_empty;
   logic [CW-1:0]           fifo_count;
   fetch_pkg::fetch_entry_t push_entry, head_entry;

   assign redirect_al = redirect_pc & ALIGN_MASK;
   assign fire        = req_valid_q && imem_req_ready;
   assign pop         = !fifo_empty && if_ready;
   assign rsp_drop    = imem_rsp_valid && (drop_cnt_q != '0);
   assign push        = imem_rsp_valid && !rsp_drop && (!fifo_full || pop);
   assign push_entry  = '{pc: rsp_pc_q, instr: imem_rsp_data};

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Next fetch state; a redirect overrides everything else in the cycle.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fire ? fetch_pc_q + PC_STEP : fetch_pc_q;
      rsp_pc_d   = push ? rsp_pc_q + PC_STEP : rsp_pc_q;
      inflight_d = inflight_q + CW'(fire) - CW'(imem_rsp_valid);
      drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
      occ_next   = fifo_count + CW'(push) - CW'(pop);

      unique case (state_q)
         fetch_pkg::WAIT:  state_d = fetch_pkg::FETCH;
         fetch_pkg::FETCH: state_d = fetch_pkg::FETCH;
         fetch_pkg::FLUSH: if (drop_cnt_q == '0) state_d = fetch_pkg::FETCH;
         default:          state_d = fetch_pkg::WAIT;
      endcase

      if (redirect_valid) begin
         fetch_pc_d = redirect_al;
         rsp_pc_d   = redirect_al;
         drop_cnt_d = inflight_d;
         occ_next   = '0;
         if (state_q == fetch_pkg::FLUSH ||
             (state_q == fetch_pkg::FETCH && inflight_d != '0)) begin
            state_d = fetch_pkg::FLUSH;
         end
      end

      // Credit rule: buffered plus outstanding words never exceed the queue depth.
      credit_used = {1'b0, occ_next} + {1'b0, inflight_d};
      req_valid_d = (state_d == fetch_pkg::FETCH) && (credit_used < CREDITS);
      req_addr_d  = fetch_pc_d & ALIGN_MASK;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= fetch_pkg::WAIT;
         fetch_pc_q  <= RESET_AL;
         rsp_pc_q    <= RESET_AL;
         req_addr_q  <= RESET_AL;
         req_valid_q <= 1'b0;
         inflight_q  <= '0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         rsp_pc_q    <= rsp_pc_d;
         req_addr_q  <= req_addr_d;
         req_valid_q <= req_valid_d;
         inflight_q  <= inflight_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = req_addr_q;
   assign if_valid       = !fifo_empty;
   assign if_instr       = head_entry.instr;
   assign if_pc          = head_entry.pc;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_q, perf_fetch_d;
   logic [31:0] perf_flush_q, perf_flush_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_fetch_d = perf_fetch_q + 32'(fire);
      perf_flush_d = perf_flush_q + 32'(redirect_valid);
      perf_stall_d = perf_stall_q + 32'(if_ready && fifo_empty);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetch_q <= '0;
         perf_flush_q <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_fetch_q <= perf_fetch_d;
         perf_flush_q <= perf_flush_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_fetch_cnt = perf_fetch_q;
   assign perf_flush_cnt = perf_flush_q;
   assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue with an in-order memory model and a queue-level reference model.
module tb_instr_fetch_queue;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          ST_WAIT  = 0;
   localparam int          ST_FETCH = 1;
   localparam int          ST_FLUSH = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            if_valid;
   logic            if_ready;
   logic [XLEN-1:0] if_instr;
   logic [XLEN-1:0] if_pc;
`ifdef FETCH_PERF_EN
   logic [31:0]     perf_fetch_cnt;
   logic [31:0]     perf_flush_cnt;
   logic [31:0]     perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   instr_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt),
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   // Reference model: fetch mode, PCs, outstanding/drop counts and the decode queue contents.
   int          m_st;
   logic [31:0] m_fpc, m_rpc;
   int          m_inflight, m_drop;
   logic [31:0] m_q[$];
   logic [31:0] mem_q[$];

   int          p_ready, p_rsp, p_ifr, p_redir;
   int          force_ready;
   bit          force_redir;
   logic [31:0] force_pc;

   int          fire_cnt, pop_cnt;
   bit          want_first_pc, got_first_pc, want_first_req, got_first_req;
   logic [31:0] first_pc, first_req, last_req;
   bit          saw_wrap, last_rspv, last_fire;

   task automatic model_reset();
      m_st = ST_WAIT;
      m_fpc = RESET_PC;
      m_rpc = RESET_PC;
      m_inflight = 0;
      m_drop = 0;
      m_q.delete();
      mem_q.delete();
      fire_cnt = 0;
      pop_cnt = 0;
      want_first_pc = 0;
      got_first_pc = 0;
      want_first_req = 0;
      got_first_req = 0;
      first_pc = '0;
      first_req = '0;
      last_req = '0;
      saw_wrap = 0;
      force_ready = -1;
      force_redir = 0;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_req_valid"}, 32'(imem_req_valid), 32'd0);
      check_eq({pfx, "_req_addr"},  imem_req_addr, RESET_PC);
      check_eq({pfx, "_if_valid"},  32'(if_valid), 32'd0);
      check_eq({pfx, "_if_instr"},  if_instr, 32'd0);
      check_eq({pfx, "_if_pc"},     if_pc, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      if_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      model_reset();
   endtask

   // One clock cycle: check outputs, drive inputs, advance memory and model, move to next negedge.
   task automatic one_cycle();
      bit          exp_rv, exp_iv, rdy, ifr, rspv, redir, fire_m, pop_m, fire_act;
      logic [31:0] rpc;
      int          old_drop;

      exp_rv = (m_st == ST_FETCH) && (m_q.size() + m_inflight < DEPTH);
      exp_iv = (m_q.size() != 0);
      check_eq("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) check_eq("req_addr", imem_req_addr, m_fpc);
      check_eq("if_valid", 32'(if_valid), 32'(exp_iv));
      if (exp_iv) begin
         check_eq("if_pc", if_pc, m_q[0]);
         check_eq("if_instr", if_instr, mem_word(m_q[0]));
      end

      rdy   = (force_ready >= 0) ? (force_ready != 0) : ($urandom_range(99) < p_ready);
      ifr   = $urandom_range(99) < p_ifr;
      rspv  = (mem_q.size() != 0) && ($urandom_range(99) < p_rsp);
      redir = force_redir || (p_redir > 0 && $urandom_range(99) < p_redir);
      if (force_redir) rpc = force_pc;
      else if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFE0 + 32'($urandom_range(31));
      else rpc = $urandom();
      force_redir = 0;

      imem_req_ready = rdy;
      if_ready       = ifr;
      imem_rsp_valid = rspv;
      imem_rsp_data  = rspv ? mem_word(mem_q[0]) : $urandom();
      redirect_valid = redir;
      redirect_pc    = rpc;

      // Memory side and trackers follow the actual handshakes.
      if (rspv) void'(mem_q.pop_front());
      fire_act = imem_req_valid && rdy;
      last_rspv = rspv;
      last_fire = fire_act;
      if (fire_act) begin
         mem_q.push_back(imem_req_addr);
         fire_cnt++;
         if (last_req == 32'hFFFF_FFFC && imem_req_addr == 32'h0) saw_wrap = 1;
         last_req = imem_req_addr;
         if (want_first_req && !redir) begin
            first_req = imem_req_addr;
            got_first_req = 1;
            want_first_req = 0;
         end
      end
      if (if_valid && ifr) begin
         pop_cnt++;
         if (want_first_pc && !redir) begin
            first_pc = if_pc;
            got_first_pc = 1;
            want_first_pc = 0;
         end
      end
      if (redir) begin
         want_first_pc = 1;
         want_first_req = 1;
      end

      fire_m = exp_rv && rdy;
      pop_m  = exp_iv && ifr;
      if (pop_m) void'(m_q.pop_front());
      old_drop = m_drop;
      if (rspv) begin
         m_inflight--;
         if (m_drop > 0) m_drop--;
         else begin
            m_q.push_back(m_rpc);
            m_rpc += 32'd4;
         end
      end
      if (fire_m) begin
         m_inflight++;
         m_fpc += 32'd4;
      end
      if (redir) begin
         m_q.delete();
         m_fpc = rpc & ~32'h3;
         m_rpc = rpc & ~32'h3;
         m_drop = m_inflight;
         if (m_st == ST_WAIT) m_st = ST_FETCH;
         else if (m_st == ST_FETCH && m_drop > 0) m_st = ST_FLUSH;
      end else if (m_st == ST_WAIT) begin
         m_st = ST_FETCH;
      end else if (m_st == ST_FLUSH && old_drop == 0) begin
         m_st = ST_FETCH;
      end

      @(negedge clk);
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) one_cycle();
   endtask

   task automatic set_knobs(input int rdy, input int rsp, input int ifr, input int rdr);
      p_ready = rdy;
      p_rsp   = rsp;
      p_ifr   = ifr;
      p_redir = rdr;
   endtask

   initial begin
      int p0;

      set_knobs(100, 100, 100, 0);
      do_reset();

      // Back-to-back streaming at one word per cycle.
      run_cycles(10);
      p0 = pop_cnt;
      run_cycles(30);
      check_eq("throughput", 32'(pop_cnt - p0), 32'd30);

      // Decode stalled: credits cap outstanding work at DEPTH, then drain in order.
      do_reset();
      set_knobs(100, 100, 0, 0);
      run_cycles(20);
      check_eq("credit_fires", 32'(fire_cnt), 32'(DEPTH));
      set_knobs(100, 100, 100, 0);
      run_cycles(20);

      // Three requests outstanding, then redirect to 0x100.
      do_reset();
      set_knobs(100, 0, 0, 0);
      for (int i = 0; i < 20 && fire_cnt < 3; i++) one_cycle();
      check_eq("pre_redirect_fires", 32'(fire_cnt), 32'd3);
      force_ready = 0;
      force_redir = 1;
      force_pc = 32'h0000_0100;
      one_cycle();
      force_ready = -1;
      set_knobs(100, 100, 100, 0);
      run_cycles(20);
      check_eq("got_first_pc_0x100", 32'(got_first_pc), 32'd1);
      check_eq("first_pc_0x100", first_pc, 32'h0000_0100);

      // Redirect coinciding with a response and a request fire.
      do_reset();
      set_knobs(100, 100, 100, 0);
      run_cycles(6);
      force_redir = 1;
      force_pc = 32'h0000_0103;
      one_cycle();
      check_eq("redir_cycle_rsp", 32'(last_rspv), 32'd1);
      check_eq("redir_cycle_fire", 32'(last_fire), 32'd1);
      run_cycles(20);
      check_eq("got_first_req_0x100", 32'(got_first_req), 32'd1);
      check_eq("first_req_0x100", first_req, 32'h0000_0100);
      check_eq("first_pc_after_0x103", first_pc, 32'h0000_0100);

      // Address wrap past the top of the address space.
      do_reset();
      set_knobs(100, 100, 100, 0);
      run_cycles(3);
      force_redir = 1;
      force_pc = 32'hFFFF_FFF4;
      one_cycle();
      run_cycles(20);
      check_eq("addr_wrap", 32'(saw_wrap), 32'd1);

      // Randomized traffic with random redirects.
      do_reset();
      for (int seg = 0; seg < 8; seg++) begin
         set_knobs(int'($urandom_range(100, 30)), int'($urandom_range(100, 20)),
                   int'($urandom_range(100, 20)), int'($urandom_range(8)));
         run_cycles(400);
      end

      // Asynchronous reset in the middle of a burst.
      set_knobs(100, 100, 100, 0);
      run_cycles(10);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("async");
      do_reset();
      run_cycles(30);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage between the PC register and decode.
- Owns the fetch PC and issues sequential requests to instruction memory over a valid/ready channel.
- Buffers returned words with their PCs in a small queue and hands them to decode over a valid/ready channel.
- Absorbs branch/jump redirects by flushing the queue and discarding in-flight responses.

Parameters:
- XLEN, 32, address/instruction width.
- DEPTH, 4, queue entries and maximum in-flight requests plus buffered words (power of 2, ≥2).
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  XLEN  new fetch target.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned request address.
- imem_rsp_valid  in  1  response word valid (in order, always accepted).
- imem_rsp_data  in  XLEN  instruction word.
- if_valid  out  1  queue head valid.
- if_ready  in  1  decode consumes head.
- if_instr  out  XLEN  head instruction.
- if_pc  out  XLEN  head PC.

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; queue empty; in-flight=0; drop_cnt=0; state=WAIT.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0.
- FSM:
  - WAIT: one idle cycle after reset release → FETCH.
  - FETCH: normal operation; redirect with drop_cnt_next>0 → FLUSH.
  - FLUSH: no requests issued; stays until drop_cnt==0 → FETCH. A further redirect while in FLUSH updates fetch_pc and stays in FLUSH.
- Request issue:
  - imem_req_valid=1 in FETCH when occupancy+inflight<DEPTH (credit rule; queue can never overflow).
  - imem_req_addr=fetch_pc with bits[1:0]=0.
  - Fire = valid&ready: fetch_pc+=4, wrapping modulo 2^XLEN; inflight++.
  - Once asserted, valid stays high with a stable address until fire, unless a redirect occurs.
- Response:
  - Each rsp_valid decrements inflight.
  - If drop_cnt>0: word discarded, drop_cnt--.
  - Otherwise {pc,instr} is pushed; pc is tracked by a separate rsp_pc counter advancing +4 per accepted response.
- Output:
  - Head registered into if_instr/if_pc; if_valid=!empty.
  - Pop on if_valid&if_ready.
  - Push and pop in the same cycle are legal at any occupancy; a word is never popped the cycle it is pushed (zero bypass).
- Latency:
  - Minimum 1 cycle from response to if_valid.
  - First request on the cycle after WAIT.
- Redirect (highest priority):
  - Queue cleared.
  - fetch_pc and rsp_pc := {redirect_pc[XLEN-1:2],2'b00}.
  - drop_cnt := inflight_next, counting a request firing and excluding a response arriving in the same cycle. A same-cycle response is itself dropped.
  - A same-cycle pop is still a valid consumption.
  - if_valid=0 the following cycle.
- Reset mid-operation clears everything immediately; responses for pre-reset requests are the memory's responsibility (memory is reset together).

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds outputs perf_fetch_cnt[31:0] (fired requests), perf_flush_cnt[31:0] (redirects) and perf_stall_cnt[31:0] (cycles with if_ready=1 and if_valid=0).
  - All counters wrap and are reset to 0.
- Undefined: these ports and counters do not exist; behaviour otherwise identical.

Decomposition:
- Package fetch_pkg:
  - XLEN, INSTR_BYTES=4, RESET_PC default, NOP_INSTR=32'h0000_0013.
  - Typedef fetch_state_t {WAIT,FETCH,FLUSH}.
  - Typedef fetch_entry_t {pc,instr}.
- Sub-module fetch_fifo:
  - Synchronous FIFO of fetch_entry_t, DEPTH entries.
  - push/pop/flush inputs; full/empty/count outputs.
  - flush dominates push.

Test Plan:
- Reset with RESET_PC=0, imem_req_ready=1, 1-cycle memory, if_ready=1 → addrs 0,4,8,… issued back to back; if_pc 0,4,8 with matching data, 1 word/cycle sustained.
- if_ready=0 held → exactly DEPTH=4 requests fire, then imem_req_valid=0. Release → PCs 0,4,8,C in order, no loss or duplicate.
- 3 requests in flight, redirect to 32'h0000_0100 → next 3 responses dropped, state FLUSH, then first if_pc=0x100.
- Redirect to 32'h0000_0103 on the same cycle as a response and a request fire → response dropped, drop_cnt counts the fired request, first req addr=0x100.
- fetch_pc=32'hFFFF_FFFC → next address 32'h0000_0000 (wrap); assert rst low mid-burst → outputs at reset values asynchronously.
